// File: rtl/pipeline_hazard_ctrl_pkg.sv
// hazard_pkg: shared state encoding and MIPS constants for the hazard controller
package hazard_pkg;
  typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: decode/EX/MEM hazard inputs and pipeline register controls
interface pipeline_hazard_ctrl_if;
  logic [4:0] ID_rs;
  logic [4:0] ID_rt;
  logic       ID_UsesRs;
  logic       ID_UsesRt;
  logic       EX_R_Enable;
  logic       EX_RegWrite;
  logic [4:0] EX_DestReg;
  logic       EX_MultiCycle;
  logic       MEM_BranchTaken;
  logic       PCWrite;
  logic       IFID_Write;
  logic       IFID_Flush;
  logic       IDEX_Write;
  logic       IDEX_Flush;
  logic       EXMEM_Flush;
  logic       MC_Busy;
  modport master (
    output ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, EX_R_Enable, EX_RegWrite, EX_DestReg,
           EX_MultiCycle, MEM_BranchTaken,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Flush, MC_Busy
  );
  modport slave (
    input  ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, EX_R_Enable, EX_RegWrite, EX_DestReg,
           EX_MultiCycle, MEM_BranchTaken,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Flush, MC_Busy
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_mc_counter.sv
// hazard_mc_counter: loadable down-counter with zero flag, saturating at zero
module hazard_mc_counter #(
  parameter int CNT_W = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Dec,
  input  logic [CNT_W-1:0] LoadValue,
  output logic             Zero
);
  logic [CNT_W-1:0] count;
  always_ff @(posedge Clock) begin
    if (Reset) count <= '0;
    else if (Load) count <= LoadValue;
    else if (Dec && count != '0) count <= count - 1'b1;
  end
  assign Zero = count == '0;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use / multi-cycle / taken-branch stall and flush sequencer.
// HAZARD_PERF_CNT_EN adds StallCycles and FlushCount performance counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 3
) (
  input logic Clock,
  input logic Reset,
  pipeline_hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
`endif
);
  localparam bit MC_EN = MC_LATENCY > 1;
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LATENCY > 1 ? MC_LATENCY - 2 : 0);
  state_t state, nextState;
  logic loadUse, mcLoad, mcDec, mcClear, mcZero;
  assign loadUse = bus.EX_R_Enable && bus.EX_RegWrite && bus.EX_DestReg != REG_ZERO &&
                   ((bus.ID_UsesRs && bus.ID_rs == bus.EX_DestReg) ||
                    (bus.ID_UsesRt && bus.ID_rt == bus.EX_DestReg));
  hazard_mc_counter #(.CNT_W(CNT_W)) u_mc_counter (
    .Clock(Clock),
    .Reset(Reset || mcClear),
    .Load(mcLoad),
    .Dec(mcDec),
    .LoadValue(MC_LOAD),
    .Zero(mcZero)
  );
  always_ff @(posedge Clock) begin
    if (Reset) state <= RUN;
    else state <= nextState;
  end
  // Branch aborts everything younger, including an in-flight multi-cycle op
  always_comb begin
    nextState       = state;
    mcLoad          = 1'b0;
    mcDec           = 1'b0;
    mcClear         = 1'b0;
    bus.PCWrite     = 1'b1;
    bus.IFID_Write  = 1'b1;
    bus.IDEX_Write  = 1'b1;
    bus.IFID_Flush  = 1'b0;
    bus.IDEX_Flush  = 1'b0;
    bus.EXMEM_Flush = 1'b0;
    bus.MC_Busy     = 1'b0;
    if (bus.MEM_BranchTaken) begin
      bus.IFID_Flush  = 1'b1;
      bus.IDEX_Flush  = 1'b1;
      bus.EXMEM_Flush = 1'b1;
      nextState       = RUN;
      mcClear         = 1'b1;
    end else if (state == MC_WAIT || (MC_EN && bus.EX_MultiCycle)) begin
      if (state == MC_WAIT && mcZero) begin
        nextState = RUN;
      end else begin
        bus.PCWrite     = 1'b0;
        bus.IFID_Write  = 1'b0;
        bus.IDEX_Write  = 1'b0;
        bus.EXMEM_Flush = 1'b1;
        bus.MC_Busy     = 1'b1;
        nextState       = MC_WAIT;
        mcLoad          = state == RUN;
        mcDec           = state == MC_WAIT;
      end
    end else if (loadUse) begin
      bus.PCWrite    = 1'b0;
      bus.IFID_Write = 1'b0;
      bus.IDEX_Flush = 1'b1;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      StallCycles <= StallCycles + {31'd0, !bus.PCWrite};
      FlushCount  <= FlushCount + {31'd0, bus.MEM_BranchTaken};
    end
  end
`endif
endmodule
